spi_master: RTL and testbench
=============================

# spi_master

Master-side SPI engine: drives `cs`, `sclk` and `mosi` and captures `miso` for one `DATA_W`-bit word per `start`. It supports all four SPI modes: CPOL = `mode[1]`, CPHA = `mode[0]`. It is the initiator counterpart of the slave-side sample/shift FSM in the same design, and its waveforms must satisfy that FSM in every mode. `cs` is active-low and idles high.

## Interface
- `DATA_W`, 8 — bits per transfer, MSB first.
- `HALF_PERIOD`, 4 — `clk` cycles per `sclk` half period; must be ≥2.
- `clk` in 1 — single clock; all logic on its rising edge.
- `reset` in 1 — reset is synchronous and active-high.
- `start` in 1 — request a transfer; accepted only when `busy`=0.
- `mode` in 2 — SPI mode; latched at accept.
- `tx_data` in `DATA_W` — word to send; latched at accept.
- `miso` in 1 — serial data from the slave.
- `cs` out 1 — chip select, active-low.
- `sclk` out 1 — serial clock.
- `mosi` out 1 — serial data to the slave.
- `rx_data` out `DATA_W` — last received word; held until the next `done`.
- `busy` out 1 — transfer in progress.
- `done` out 1 — one-cycle pulse at the end of a transfer.

## Operation
- **States and transitions:**
  - IDLE: on `start` go to SETUP.
  - SETUP: lasts H cycles, then LEAD.
  - LEAD: lasts H cycles, then TRAIL.
  - TRAIL: lasts H cycles, then LEAD while edges < 2·`DATA_W`, else HOLD.
  - HOLD: lasts H cycles, then IDLE with `done`.
  - H = `HALF_PERIOD`. Any undefined state goes to IDLE.
- **Reset values:** `cs`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0, latched mode=0.
- **Accept:** `start`=1 in IDLE latches `mode` into cpol/cpha and `tx_data` into the TX shift register. It also clears the edge counter and the RX shift register. `mode`/`tx_data` changes during a transfer are ignored.
- **sclk:**
  - Equals the latched CPOL in IDLE, SETUP and HOLD.
  - Equals ~CPOL in LEAD and CPOL in TRAIL.
  - Entering LEAD is a leading edge; entering TRAIL is a trailing edge. Exactly 2·`DATA_W` edges per transfer.
- **mosi:** equals the TX shift register MSB while `busy`, and 0 otherwise.
- **Shift edges** (TX register shifts left by one):
  - CPHA=0: trailing edges, except the last one.
  - CPHA=1: leading edges, except the first one.
- **Sample edges** (`miso` is shifted into the RX LSB on the `clk` edge that produces the sclk edge):
  - CPHA=0: leading edges.
  - CPHA=1: trailing edges.
- **Completion:** `rx_data` is loaded from the RX shift register in the same cycle `done`=1.
- **Boundary conditions:**
  - `start` while `busy`: ignored, with no side effects.
  - `start` in the `done` cycle: accepted, because `busy`=0 there. `cs` is then high for exactly 1 cycle between words.
  - `reset` mid-transfer: next cycle all outputs take their reset values. No `done` pulse; `rx_data` is cleared.

## Timing
- Cycle 0 is the accept cycle.
- `busy`=1 and `cs`=0 for cycles 1..(2·`DATA_W`+2)·H inclusive.
- Edge k (k=1..2·`DATA_W`) appears on `sclk` at cycle k·H+1.
- `done`=1, `cs`=1 and `busy`=0 at cycle (2·`DATA_W`+2)·H+1.
- Defaults (`DATA_W`=8, H=4): first edge at cycle 5, last edge at cycle 65, `done` at cycle 73.
- `mosi` is stable for H cycles before every sample edge. This includes bit `DATA_W`-1, which is valid from cycle 1 for CPHA=0.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `spi_pkg` holds:
  - the state encoding (IDLE, SETUP, LEAD, TRAIL, HOLD);
  - mode constants MODE0..MODE3;
  - the CPOL/CPHA bit indices (1 and 0).
- The slave FSM imports the same package.
- One sub-module, `spi_half_timer`: counts 0..H-1, is restarted by the FSM, and emits a terminal-count pulse.
- The edge counter (0..2·`DATA_W`) and the TX/RX shift registers live in `spi_master`.

## Test plan
- **Mode 0 loopback:** mode 0, `tx_data`=0xA5, `miso` tied to `mosi` → `rx_data`=0xA5, `done` at cycle 73, 8 rising `sclk` edges, `sclk` idle 0.
- **Mode 3:** mode 3, `tx_data`=0x3C, `miso`=1 → `sclk` idles 1, first edge falling at cycle 5, `rx_data`=0xFF, `mosi` sequence 0,0,1,1,1,1,0,0.
- **Modes 1 and 2:** slave model returns 0x5A → `rx_data`=0x5A. The `mosi` change points land on the leading edge for CPHA=1 and the trailing edge for CPHA=0.
- **Start while busy:** `start` with `tx_data`=0xFF at cycle 20 of a 0x00 transfer → ignored; `mosi` stays 0; only one `done`.
- **Back-to-back:** `start` in the `done` cycle → `cs` high for exactly 1 cycle, then a second transfer completes normally.
- **Reset mid-transfer:** `reset` at cycle 30 → next cycle `cs`=1, `sclk`=0, `busy`=0, `rx_data`=0, no `done`. A following `start` works.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI state encoding and mode constants
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LEAD,
        ST_TRAIL,
        ST_HOLD
    } state_e;

    localparam logic [1:0] MODE0 = 2'd0;
    localparam logic [1:0] MODE1 = 2'd1;
    localparam logic [1:0] MODE2 = 2'd2;
    localparam logic [1:0] MODE3 = 2'd3;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

endpackage

// File: rtl/spi_half_timer.sv
// rtl/spi_half_timer.sv - sclk half-period timer with terminal-count pulse
module spi_half_timer #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic restart_i,
    output logic tc_o
);

    localparam int CW = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || restart_i || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI master engine, one DATA_W-bit word per start, modes 0..3
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int HALF_PERIOD = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              miso_i,
    output logic              cs_o,
    output logic              sclk_o,
    output logic              mosi_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int EW = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0] LAST_EDGE   = EW'(2 * DATA_W);
    localparam logic [EW-1:0] PENULT_EDGE = EW'(2 * DATA_W - 1);

    state_e            state_q, state_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d;
    logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic              cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              accept, tc, lead_edge, trail_edge;

    assign accept = (state_q == ST_IDLE) && start_i;

    spi_half_timer #(.HALF_PERIOD(HALF_PERIOD)) u_timer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .restart_i(accept),
        .tc_o     (tc)
    );

    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        edge_d     = edge_q;
        rx_data_d  = rx_data_q;
        done_d     = 1'b0;
        lead_edge  = 1'b0;
        trail_edge = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SETUP;
                    cpol_d  = mode_i[CPOL_BIT];
                    cpha_d  = mode_i[CPHA_BIT];
                    tx_d    = tx_data_i;
                    rx_d    = '0;
                    edge_d  = '0;
                end
            end
            ST_SETUP: if (tc) begin state_d = ST_LEAD;  lead_edge  = 1'b1; end
            ST_LEAD:  if (tc) begin state_d = ST_TRAIL; trail_edge = 1'b1; end
            ST_TRAIL: begin
                if (tc) begin
                    if (edge_q < LAST_EDGE) begin
                        state_d   = ST_LEAD;
                        lead_edge = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (tc) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    rx_data_d = rx_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Edge k is counted as it is produced, so edge_q holds k-1 when acting on edge k.
        if (lead_edge || trail_edge) edge_d = edge_q + EW'(1);
        if (lead_edge) begin
            if (!cpha_q)             rx_d = {rx_q[DATA_W-2:0], miso_i};
            else if (edge_q != '0)   tx_d = {tx_q[DATA_W-2:0], 1'b0};
        end
        if (trail_edge) begin
            if (cpha_q)                   rx_d = {rx_q[DATA_W-2:0], miso_i};
            else if (edge_q != PENULT_EDGE) tx_d = {tx_q[DATA_W-2:0], 1'b0};
        end

        busy_d = (state_d != ST_IDLE);
        cs_d   = ~busy_d;
        sclk_d = (state_d == ST_LEAD) ? ~cpol_d : cpol_d;
        mosi_d = busy_d & tx_d[DATA_W-1];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q          <= ST_IDLE;
            {cpol_q, cpha_q} <= MODE0;
            tx_q             <= '0;
            rx_q             <= '0;
            edge_q           <= '0;
            rx_data_q        <= '0;
            cs_q             <= 1'b1;
            sclk_q           <= 1'b0;
            mosi_q           <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            edge_q    <= edge_d;
            rx_data_q <= rx_data_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign cs_o      = cs_q;
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign rx_data_o = rx_data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master against a cycle-formula reference
module tb_spi_master;
    import spi_pkg::*;

    localparam int D     = 8;
    localparam int H     = 4;
    localparam int TDONE = (2 * D + 2) * H + 1;

    logic         clk = 1'b0;
    logic         reset, start, miso, loop_en, slave_bit;
    logic [1:0]   mode;
    logic [D-1:0] tx_data;
    logic         cs, sclk, mosi, busy, done;
    logic [D-1:0] rx_data;
    logic [D-1:0] prev_rx;

    int n_pass  = 0;
    int n_total = 0;
    int ndone;

    always #5 clk = ~clk;

    assign miso = loop_en ? mosi : slave_bit;

    spi_master #(.DATA_W(D), .HALF_PERIOD(H)) dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .start_i  (start),
        .mode_i   (mode),
        .tx_data_i(tx_data),
        .miso_i   (miso),
        .cs_o     (cs),
        .sclk_o   (sclk),
        .mosi_o   (mosi),
        .rx_data_o(rx_data),
        .busy_o   (busy),
        .done_o   (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // Number of sclk edges visible at cycle c: edge k shows at cycle k*H+1.
    function automatic int edges_at(input int c);
        int e;
        if (c < H + 1) return 0;
        e = (c - 1) / H;
        return (e > 2 * D) ? 2 * D : e;
    endfunction

    task automatic xfer(input logic [1:0] md, input logic [D-1:0] tx, input logic [D-1:0] sw,
                        input bit loop, input bit prestarted, input int spur_cyc,
                        input bit chain, input logic [1:0] nmd, input logic [D-1:0] ntx);
        int e, sh, sm, nd;
        logic cp, ph, busy_e;
        logic [D-1:0] exp_rx;
        cp     = md[CPOL_BIT];
        ph     = md[CPHA_BIT];
        exp_rx = loop ? tx : sw;
        nd     = 0;
        if (!prestarted) begin
            @(negedge clk);
            start = 1'b1; mode = md; tx_data = tx;
        end
        loop_en   = loop;
        slave_bit = sw[D-1];
        for (int c = 1; c <= TDONE + (chain ? 0 : 2); c++) begin
            @(negedge clk);
            e      = edges_at(c);
            busy_e = (c < TDONE);
            sh     = ph ? ((e >= 1) ? (e - 1) / 2 : 0) : ((e / 2 > D - 1) ? D - 1 : e / 2);
            sm     = ph ? e / 2 : (e + 1) / 2;
            if (done) nd++;
            chk("cs", cs, !busy_e);
            chk("busy", busy, busy_e);
            chk("sclk", sclk, cp ^ e[0]);
            chk("mosi", mosi, busy_e ? tx[D-1-sh] : 1'b0);
            chk("done", done, c == TDONE);
            if (c == TDONE - 1) chk("rx_hold", rx_data, prev_rx);
            if (c >= TDONE) chk("rx_data", rx_data, exp_rx);
            slave_bit = (sm < D) ? sw[D-1-sm] : 1'b0;
            if (c == spur_cyc) begin
                start = 1'b1; tx_data = '1; mode = ~md;
            end else begin
                start = 1'b0;
            end
            if (chain && c == TDONE) begin
                start = 1'b1; mode = nmd; tx_data = ntx;
            end
        end
        chk("done_count", nd, 1);
        prev_rx = exp_rx;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = MODE0; tx_data = '0;
        loop_en = 1'b0; slave_bit = 1'b0; prev_rx = '0;
        @(negedge clk);
        chk("rst_cs", cs, 1'b1);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rx", rx_data, '0);
        @(negedge clk);
        reset = 1'b0;

        xfer(MODE0, 8'hA5, 8'h00, 1'b1, 1'b0, 0, 1'b0, MODE0, '0);
        xfer(MODE3, 8'h3C, 8'hFF, 1'b0, 1'b0, 0, 1'b0, MODE0, '0);
        xfer(MODE1, 8'h96, 8'h5A, 1'b0, 1'b0, 0, 1'b0, MODE0, '0);
        xfer(MODE2, 8'h69, 8'h5A, 1'b0, 1'b0, 0, 1'b0, MODE0, '0);
        xfer(MODE0, 8'h00, 8'hC6, 1'b0, 1'b0, 20, 1'b0, MODE0, '0);
        xfer(MODE2, 8'h81, 8'h7E, 1'b0, 1'b0, 0, 1'b1, MODE1, 8'h42);
        xfer(MODE1, 8'h42, 8'h99, 1'b0, 1'b1, 0, 1'b0, MODE0, '0);

        @(negedge clk);
        start = 1'b1; mode = MODE1; tx_data = 8'hC3; loop_en = 1'b0; slave_bit = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_cs", cs, 1'b1);
        chk("mid_rst_sclk", sclk, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_mosi", mosi, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_rx", rx_data, '0);
        ndone = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mid_rst_no_done", ndone, 0);
        prev_rx = '0;
        xfer(MODE0, 8'h5C, 8'hE1, 1'b0, 1'b0, 0, 1'b0, MODE0, '0);

        for (int i = 0; i < 6; i++) begin
            xfer(2'($urandom_range(3)), 8'($urandom), 8'($urandom), 1'($urandom_range(1)),
                 1'b0, 0, 1'b0, MODE0, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
